axi_line_bridge: RTL and testbench

- Parametrised successor of the single-beat SRAM-to-AXI bridge.
- Sits between the icache/dcache miss and writeback logic and the AXI master port.
- Serves two read clients (inst, arid 0; data, arid 1) and one data write client, using cache-style req/rdy plus return-beat interfaces.
- Handles LINE_WORDS-beat INCR bursts and single-beat uncached accesses, with a line write buffer and read-after-write line hazard blocking.

---
 rtl/axi_line_bridge.sv | 327 ++++++++++++++++++++++++++++++++
 tb/tb_axi_line_bridge.sv | 516 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_line_bridge.sv
// axi_line_bridge: cache miss/writeback to AXI3 master bridge.
// Two read clients (inst, data) share one outstanding AR/R transaction;
// one data write client owns a line write buffer that drains over AW/W/B.
// Data reads that hit the line currently held in the write buffer are
// stalled until the write response returns, so a refill never observes
// stale memory contents.
module axi_line_bridge #(
    parameter int         LINE_WORDS = 4,
    parameter int         ADDR_W     = 32,
    parameter logic [3:0] INST_ID    = 4'd0,
    parameter logic [3:0] DATA_ID    = 4'd1
) (
    input  logic                       aclk,
    input  logic                       aresetn,

    // AXI read address channel
    output logic [3:0]                 arid,
    output logic [ADDR_W-1:0]          araddr,
    output logic [7:0]                 arlen,
    output logic [2:0]                 arsize,
    output logic [1:0]                 arburst,
    output logic [1:0]                 arlock,
    output logic [3:0]                 arcache,
    output logic [2:0]                 arprot,
    output logic                       arvalid,
    input  logic                       arready,

    // AXI read data channel
    input  logic [3:0]                 rid,
    input  logic [31:0]                rdata,
    input  logic [1:0]                 rresp,
    input  logic                       rlast,
    input  logic                       rvalid,
    output logic                       rready,

    // AXI write address channel
    output logic [3:0]                 awid,
    output logic [ADDR_W-1:0]          awaddr,
    output logic [7:0]                 awlen,
    output logic [2:0]                 awsize,
    output logic [1:0]                 awburst,
    output logic [1:0]                 awlock,
    output logic [3:0]                 awcache,
    output logic [2:0]                 awprot,
    output logic                       awvalid,
    input  logic                       awready,

    // AXI write data channel
    output logic [3:0]                 wid,
    output logic [31:0]                wdata,
    output logic [3:0]                 wstrb,
    output logic                       wlast,
    output logic                       wvalid,
    input  logic                       wready,

    // AXI write response channel
    input  logic [3:0]                 bid,
    input  logic [1:0]                 bresp,
    input  logic                       bvalid,
    output logic                       bready,

    // Instruction read client
    input  logic                       i_rd_req,
    input  logic [2:0]                 i_rd_type,
    input  logic [ADDR_W-1:0]          i_rd_addr,
    output logic                       i_rd_rdy,
    output logic                       i_ret_valid,
    output logic                       i_ret_last,
    output logic [31:0]                i_ret_data,

    // Data read client
    input  logic                       d_rd_req,
    input  logic [2:0]                 d_rd_type,
    input  logic [ADDR_W-1:0]          d_rd_addr,
    output logic                       d_rd_rdy,
    output logic                       d_ret_valid,
    output logic                       d_ret_last,
    output logic [31:0]                d_ret_data,

    // Data write client
    input  logic                       d_wr_req,
    input  logic [2:0]                 d_wr_type,
    input  logic [ADDR_W-1:0]          d_wr_addr,
    input  logic [3:0]                 d_wr_wstrb,
    input  logic [32*LINE_WORDS-1:0]   d_wr_data,
    output logic                       d_wr_rdy,
    output logic                       d_wr_done
);

    // Byte offset bits inside one cache line; used for the line-match hazard.
    localparam int OFF   = $clog2(LINE_WORDS * 4);
    // Index width into the write line buffer.
    localparam int CNT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_AR   = 2'd1,
        R_DATA = 2'd2
    } rstate_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_AW   = 2'd1,
        W_DATA = 2'd2,
        W_B    = 2'd3
    } wstate_t;

    // Burst length for a request type: full line burst or a single beat.
    function automatic logic [7:0] f_len(input logic [2:0] t);
        return t[2] ? 8'(LINE_WORDS - 1) : 8'd0;
    endfunction

    // Transfer size: lines move as words, uncached accesses use their own width.
    function automatic logic [2:0] f_size(input logic [2:0] t);
        return t[2] ? 3'b010 : {1'b0, t[1:0]};
    endfunction

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    rstate_t             r_rstate;
    rstate_t             w_rstate_next;
    logic                w_grant_d;
    logic                w_grant_i;
    logic                w_hazard;
    logic [3:0]          r_arid;
    logic [ADDR_W-1:0]   r_araddr;
    logic [7:0]          r_arlen;
    logic [2:0]          r_arsize;
    logic                r_rd_is_data;
    logic                w_r_beat;

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    wstate_t             r_wstate;
    wstate_t             w_wstate_next;
    logic                w_wr_accept;
    logic [ADDR_W-1:0]   r_awaddr;
    logic [2:0]          r_wtype;
    logic [3:0]          r_wstrb;
    logic [7:0]          r_wcnt;
    logic [31:0]         r_wbuf [LINE_WORDS];
    logic [31:0]         w_line_words [LINE_WORDS];
    logic                w_wlast;

    // Split the flat write line into words; word 0 sits in the low bits.
    for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_line_words
        assign w_line_words[gi] = d_wr_data[32*gi +: 32];
    end

    // A data read that targets the line being written back must wait.
    assign w_hazard = (r_wstate != W_IDLE) &&
                      (d_rd_addr[ADDR_W-1:OFF] == r_awaddr[ADDR_W-1:OFF]);

    // Read arbitration and next-state: data wins over inst when not hazarded.
    always_comb begin
        w_rstate_next = r_rstate;
        w_grant_d     = 1'b0;
        w_grant_i     = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                if (aresetn) begin
                    if (d_rd_req && !w_hazard) begin
                        w_grant_d     = 1'b1;
                        w_rstate_next = R_AR;
                    end else if (i_rd_req) begin
                        w_grant_i     = 1'b1;
                        w_rstate_next = R_AR;
                    end
                end
            end
            R_AR: begin
                if (arready) begin
                    w_rstate_next = R_DATA;
                end
            end
            R_DATA: begin
                if (rvalid && rlast) begin
                    w_rstate_next = R_IDLE;
                end
            end
            default: w_rstate_next = R_IDLE;
        endcase
    end

    // Read state register and AR payload capture on grant.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_rstate     <= R_IDLE;
            r_arid       <= 4'd0;
            r_araddr     <= '0;
            r_arlen      <= 8'd0;
            r_arsize     <= 3'd0;
            r_rd_is_data <= 1'b0;
        end else begin
            r_rstate <= w_rstate_next;
            if (w_grant_d) begin
                r_arid       <= DATA_ID;
                r_araddr     <= d_rd_addr;
                r_arlen      <= f_len(d_rd_type);
                r_arsize     <= f_size(d_rd_type);
                r_rd_is_data <= 1'b1;
            end else if (w_grant_i) begin
                r_arid       <= INST_ID;
                r_araddr     <= i_rd_addr;
                r_arlen      <= f_len(i_rd_type);
                r_arsize     <= f_size(i_rd_type);
                r_rd_is_data <= 1'b0;
            end
        end
    end

    assign i_rd_rdy = w_grant_i;
    assign d_rd_rdy = w_grant_d;

    assign arid    = r_arid;
    assign araddr  = r_araddr;
    assign arlen   = r_arlen;
    assign arsize  = r_arsize;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;
    assign arvalid = aresetn && (r_rstate == R_AR);
    assign rready  = aresetn && (r_rstate == R_DATA);

    // R beats are steered to the client that owns the outstanding read.
    assign w_r_beat    = rready && rvalid;
    assign i_ret_valid = w_r_beat && !r_rd_is_data;
    assign d_ret_valid = w_r_beat &&  r_rd_is_data;
    assign i_ret_last  = rlast;
    assign d_ret_last  = rlast;
    assign i_ret_data  = rdata;
    assign d_ret_data  = rdata;

    // Write next-state: accept into buffer, address phase, data beats, response.
    always_comb begin
        w_wstate_next = r_wstate;
        w_wr_accept   = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                if (aresetn && d_wr_req) begin
                    w_wr_accept   = 1'b1;
                    w_wstate_next = W_AW;
                end
            end
            W_AW: begin
                if (awready) begin
                    w_wstate_next = W_DATA;
                end
            end
            W_DATA: begin
                if (wready && w_wlast) begin
                    w_wstate_next = W_B;
                end
            end
            W_B: begin
                if (bvalid) begin
                    w_wstate_next = W_IDLE;
                end
            end
            default: w_wstate_next = W_IDLE;
        endcase
    end

    // Write state register, request capture and beat counter.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_wstate <= W_IDLE;
            r_awaddr <= '0;
            r_wtype  <= 3'd0;
            r_wstrb  <= 4'd0;
            r_wcnt   <= 8'd0;
        end else begin
            r_wstate <= w_wstate_next;
            if (w_wr_accept) begin
                r_awaddr <= d_wr_addr;
                r_wtype  <= d_wr_type;
                r_wstrb  <= d_wr_wstrb;
                r_wcnt   <= 8'd0;
            end else if (wvalid && wready) begin
                r_wcnt <= r_wcnt + 8'd1;
            end
        end
    end

    // Line buffer holds the whole writeback so the cache can move on.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            for (int k = 0; k < LINE_WORDS; k++) begin
                r_wbuf[k] <= 32'd0;
            end
        end else if (w_wr_accept) begin
            for (int k = 0; k < LINE_WORDS; k++) begin
                r_wbuf[k] <= w_line_words[k];
            end
        end
    end

    assign w_wlast = (r_wcnt == f_len(r_wtype));

    assign awid    = DATA_ID;
    assign awaddr  = r_awaddr;
    assign awlen   = f_len(r_wtype);
    assign awsize  = f_size(r_wtype);
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'b0000;
    assign awprot  = 3'b000;
    assign awvalid = aresetn && (r_wstate == W_AW);

    assign wid    = DATA_ID;
    assign wdata  = r_wbuf[r_wcnt[CNT_W-1:0]];
    assign wstrb  = r_wtype[2] ? 4'hF : r_wstrb;
    assign wlast  = w_wlast;
    assign wvalid = aresetn && (r_wstate == W_DATA);

    assign bready    = aresetn && (r_wstate == W_B);
    assign d_wr_done = bready && bvalid;
    assign d_wr_rdy  = aresetn && (r_wstate == W_IDLE);

    // Response ids and status codes carry no routing information here.
    logic w_unused_ok;
    assign w_unused_ok = ^{rid, rresp, bid, bresp};

endmodule

// File: tb/tb_axi_line_bridge.sv
// Directed testbench for axi_line_bridge (LINE_WORDS = 4).
module tb_axi_line_bridge;

    logic         aclk;
    logic         aresetn;
    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic [1:0]   arlock;
    logic [3:0]   arcache;
    logic [2:0]   arprot;
    logic         arvalid;
    logic         arready;
    logic [3:0]   rid;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;
    logic [3:0]   awid;
    logic [31:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic [1:0]   awlock;
    logic [3:0]   awcache;
    logic [2:0]   awprot;
    logic         awvalid;
    logic         awready;
    logic [3:0]   wid;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wlast;
    logic         wvalid;
    logic         wready;
    logic [3:0]   bid;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic         i_rd_req;
    logic [2:0]   i_rd_type;
    logic [31:0]  i_rd_addr;
    logic         i_rd_rdy;
    logic         i_ret_valid;
    logic         i_ret_last;
    logic [31:0]  i_ret_data;
    logic         d_rd_req;
    logic [2:0]   d_rd_type;
    logic [31:0]  d_rd_addr;
    logic         d_rd_rdy;
    logic         d_ret_valid;
    logic         d_ret_last;
    logic [31:0]  d_ret_data;
    logic         d_wr_req;
    logic [2:0]   d_wr_type;
    logic [31:0]  d_wr_addr;
    logic [3:0]   d_wr_wstrb;
    logic [127:0] d_wr_data;
    logic         d_wr_rdy;
    logic         d_wr_done;

    int vectors     = 0;
    int miscompares = 0;

    axi_line_bridge #(.LINE_WORDS(4), .ADDR_W(32)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr), .i_rd_rdy(i_rd_rdy),
        .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last), .i_ret_data(i_ret_data),
        .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr), .d_rd_rdy(d_rd_rdy),
        .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last), .d_ret_data(d_ret_data),
        .d_wr_req(d_wr_req), .d_wr_type(d_wr_type), .d_wr_addr(d_wr_addr),
        .d_wr_wstrb(d_wr_wstrb), .d_wr_data(d_wr_data),
        .d_wr_rdy(d_wr_rdy), .d_wr_done(d_wr_done)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        i_rd_req = 1'b1; d_rd_req = 1'b1; d_wr_req = 1'b1;
        tick(); tick();
        #1;
        vectors++;
        if ({i_rd_rdy, d_rd_rdy, d_wr_rdy} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_rdy got %b want 000", {i_rd_rdy, d_rd_rdy, d_wr_rdy});
        end
        vectors++;
        if ({arvalid, rready, awvalid, wvalid, bready, i_ret_valid, d_ret_valid, d_wr_done} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_valids got %b want 00000000",
                     {arvalid, rready, awvalid, wvalid, bready, i_ret_valid, d_ret_valid, d_wr_done});
        end
        vectors++;
        if ({araddr, arlen, awaddr} !== 72'd0) begin
            miscompares++;
            $display("FAIL reset_payload got araddr=%h arlen=%h awaddr=%h want 0", araddr, arlen, awaddr);
        end
        i_rd_req = 1'b0; d_rd_req = 1'b0; d_wr_req = 1'b0;
        tick();
        aresetn = 1'b1;
        #1;
        vectors++;
        if (d_wr_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_wr_rdy got %b want 1", d_wr_rdy);
        end
        $display("test_reset: reset applied and released");
    endtask

    task automatic test_inst_line();
        logic [31:0] exp_d;
        tick();
        i_rd_req = 1'b1; i_rd_type = 3'b100; i_rd_addr = 32'h1C00_0040;
        #1;
        vectors++;
        if ({i_rd_rdy, d_rd_rdy} !== 2'b10) begin
            miscompares++;
            $display("FAIL inst_grant got %b want 10", {i_rd_rdy, d_rd_rdy});
        end
        tick();
        i_rd_req = 1'b0; arready = 1'b1;
        #1;
        vectors++;
        if ({arvalid, arid, araddr, arlen, arsize} !== {1'b1, 4'd0, 32'h1C00_0040, 8'd3, 3'd2}) begin
            miscompares++;
            $display("FAIL inst_ar got v=%b id=%h a=%h len=%h sz=%h want 1 0 1c000040 03 2",
                     arvalid, arid, araddr, arlen, arsize);
        end
        vectors++;
        if ({arburst, arlock, arcache, arprot} !== {2'b01, 2'b00, 4'b0000, 3'b000}) begin
            miscompares++;
            $display("FAIL ar_consts got %b want 01000000000", {arburst, arlock, arcache, arprot});
        end
        tick();
        arready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_d = 32'hA000_0000 + 32'(k);
            rvalid = 1'b1; rdata = exp_d; rlast = (k == 3);
            #1;
            vectors++;
            if ({i_ret_valid, i_ret_last, i_ret_data, d_ret_valid, rready} !==
                {1'b1, (k == 3), exp_d, 1'b0, 1'b1}) begin
                miscompares++;
                $display("FAIL inst_beat%0d got v=%b l=%b d=%h dv=%b rr=%b want 1 %b %h 0 1",
                         k, i_ret_valid, i_ret_last, i_ret_data, d_ret_valid, rready, (k == 3), exp_d);
            end
            tick();
        end
        rvalid = 1'b0; rlast = 1'b0;
        #1;
        vectors++;
        if ({arvalid, rready, i_ret_valid} !== 3'b000) begin
            miscompares++;
            $display("FAIL inst_done_idle got %b want 000", {arvalid, rready, i_ret_valid});
        end
        $display("test_inst_line: line read 1c000040 four beats");
    endtask

    task automatic test_priority();
        tick();
        i_rd_req = 1'b1; i_rd_type = 3'b100; i_rd_addr = 32'h1C00_0080;
        d_rd_req = 1'b1; d_rd_type = 3'b010; d_rd_addr = 32'h0000_0080;
        #1;
        vectors++;
        if ({d_rd_rdy, i_rd_rdy} !== 2'b10) begin
            miscompares++;
            $display("FAIL prio_grant got d=%b i=%b want d=1 i=0", d_rd_rdy, i_rd_rdy);
        end
        tick();
        d_rd_req = 1'b0; arready = 1'b1;
        #1;
        vectors++;
        if ({arvalid, arid, araddr, arlen, arsize, i_rd_rdy} !== {1'b1, 4'd1, 32'h80, 8'd0, 3'd2, 1'b0}) begin
            miscompares++;
            $display("FAIL prio_data_ar got v=%b id=%h a=%h len=%h sz=%h irdy=%b want 1 1 00000080 00 2 0",
                     arvalid, arid, araddr, arlen, arsize, i_rd_rdy);
        end
        tick();
        arready = 1'b0; rvalid = 1'b1; rlast = 1'b1; rdata = 32'h1234_5678;
        #1;
        vectors++;
        if ({d_ret_valid, d_ret_last, d_ret_data, i_ret_valid, i_rd_rdy} !== {1'b1, 1'b1, 32'h1234_5678, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL prio_data_beat got dv=%b dl=%b d=%h iv=%b irdy=%b want 1 1 12345678 0 0",
                     d_ret_valid, d_ret_last, d_ret_data, i_ret_valid, i_rd_rdy);
        end
        tick();
        rvalid = 1'b0; rlast = 1'b0;
        #1;
        vectors++;
        if (i_rd_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL prio_inst_after got %b want 1", i_rd_rdy);
        end
        tick();
        i_rd_req = 1'b0; arready = 1'b1;
        #1;
        vectors++;
        if ({arvalid, arid, araddr, arlen} !== {1'b1, 4'd0, 32'h1C00_0080, 8'd3}) begin
            miscompares++;
            $display("FAIL prio_inst_ar got v=%b id=%h a=%h len=%h want 1 0 1c000080 03",
                     arvalid, arid, araddr, arlen);
        end
        tick();
        arready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rvalid = 1'b1; rdata = 32'(k); rlast = (k == 3);
            tick();
        end
        rvalid = 1'b0; rlast = 1'b0;
        $display("test_priority: data word 80 then inst line 1c000080");
    endtask

    task automatic test_line_write();
        logic [31:0] w [4];
        int k;
        int c;
        w[0] = 32'hD0D0_0000; w[1] = 32'hD1D1_1111; w[2] = 32'hD2D2_2222; w[3] = 32'hD3D3_3333;
        tick();
        d_wr_req = 1'b1; d_wr_type = 3'b100; d_wr_addr = 32'h100; d_wr_wstrb = 4'b0000;
        d_wr_data = {w[3], w[2], w[1], w[0]};
        #1;
        vectors++;
        if (d_wr_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL lw_rdy got %b want 1", d_wr_rdy);
        end
        tick();
        d_wr_req = 1'b0; awready = 1'b1;
        #1;
        vectors++;
        if ({awvalid, wvalid, awid, awaddr, awlen, awsize, d_wr_rdy} !==
            {1'b1, 1'b0, 4'd1, 32'h100, 8'd3, 3'd2, 1'b0}) begin
            miscompares++;
            $display("FAIL lw_aw got v=%b wv=%b id=%h a=%h len=%h sz=%h rdy=%b want 1 0 1 00000100 03 2 0",
                     awvalid, wvalid, awid, awaddr, awlen, awsize, d_wr_rdy);
        end
        tick();
        awready = 1'b0;
        k = 0; c = 0;
        while (k < 4 && c < 12) begin
            wready = (c % 2 == 0);
            #1;
            vectors++;
            if ({wvalid, wid, wdata, wstrb, wlast, awvalid} !== {1'b1, 4'd1, w[k], 4'hF, (k == 3), 1'b0}) begin
                miscompares++;
                $display("FAIL lw_beat%0d got v=%b id=%h d=%h s=%h l=%b awv=%b want 1 1 %h f %b 0",
                         k, wvalid, wid, wdata, wstrb, wlast, awvalid, w[k], (k == 3));
            end
            if (wready) k++;
            tick();
            c++;
        end
        wready = 1'b0;
        #1;
        vectors++;
        if ({wvalid, bready, d_wr_done} !== 3'b010) begin
            miscompares++;
            $display("FAIL lw_wait_b got %b want 010", {wvalid, bready, d_wr_done});
        end
        tick();
        bvalid = 1'b1;
        #1;
        vectors++;
        if (d_wr_done !== 1'b1) begin
            miscompares++;
            $display("FAIL lw_done got %b want 1", d_wr_done);
        end
        tick();
        bvalid = 1'b0;
        #1;
        vectors++;
        if ({d_wr_done, d_wr_rdy, bready} !== 3'b010) begin
            miscompares++;
            $display("FAIL lw_after got %b want 010", {d_wr_done, d_wr_rdy, bready});
        end
        $display("test_line_write: line 100 four beats with wready toggling");
    endtask

    task automatic test_byte_write();
        tick();
        d_wr_req = 1'b1; d_wr_type = 3'b000; d_wr_addr = 32'h203; d_wr_wstrb = 4'b1000;
        d_wr_data = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'hAABB_CCDD};
        tick();
        d_wr_req = 1'b0; awready = 1'b1;
        #1;
        vectors++;
        if ({awvalid, awaddr, awlen, awsize} !== {1'b1, 32'h203, 8'd0, 3'd0}) begin
            miscompares++;
            $display("FAIL bw_aw got v=%b a=%h len=%h sz=%h want 1 00000203 00 0",
                     awvalid, awaddr, awlen, awsize);
        end
        tick();
        awready = 1'b0; wready = 1'b1;
        #1;
        vectors++;
        if ({wvalid, wdata, wstrb, wlast} !== {1'b1, 32'hAABB_CCDD, 4'b1000, 1'b1}) begin
            miscompares++;
            $display("FAIL bw_beat got v=%b d=%h s=%b l=%b want 1 aabbccdd 1000 1",
                     wvalid, wdata, wstrb, wlast);
        end
        tick();
        wready = 1'b0; bvalid = 1'b1;
        #1;
        vectors++;
        if ({wvalid, bready, d_wr_done} !== 3'b011) begin
            miscompares++;
            $display("FAIL bw_b got %b want 011", {wvalid, bready, d_wr_done});
        end
        tick();
        bvalid = 1'b0;
        $display("test_byte_write: byte 203 strb 1000");
    endtask

    task automatic test_hazard();
        tick();
        d_wr_req = 1'b1; d_wr_type = 3'b100; d_wr_addr = 32'h100; d_wr_wstrb = 4'hF;
        d_wr_data = {32'h4, 32'h3, 32'h2, 32'h1};
        tick();
        d_wr_req = 1'b0;
        d_rd_req = 1'b1; d_rd_type = 3'b010; d_rd_addr = 32'h108;
        #1;
        vectors++;
        if (d_rd_rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL hz_blocked got %b want 0", d_rd_rdy);
        end
        tick();
        d_rd_addr = 32'h200;
        #1;
        vectors++;
        if (d_rd_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL hz_other_line got %b want 1", d_rd_rdy);
        end
        tick();
        d_rd_addr = 32'h108; arready = 1'b1;
        #1;
        vectors++;
        if ({arvalid, araddr, awvalid} !== {1'b1, 32'h200, 1'b1}) begin
            miscompares++;
            $display("FAIL hz_other_ar got v=%b a=%h awv=%b want 1 00000200 1", arvalid, araddr, awvalid);
        end
        tick();
        arready = 1'b0; rvalid = 1'b1; rlast = 1'b1; rdata = 32'h55;
        #1;
        vectors++;
        if ({d_ret_valid, d_ret_data} !== {1'b1, 32'h55}) begin
            miscompares++;
            $display("FAIL hz_other_beat got v=%b d=%h want 1 00000055", d_ret_valid, d_ret_data);
        end
        tick();
        rvalid = 1'b0; rlast = 1'b0; awready = 1'b1;
        #1;
        vectors++;
        if (d_rd_rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL hz_blocked_aw got %b want 0", d_rd_rdy);
        end
        tick();
        awready = 1'b0; wready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            vectors++;
            if ({d_rd_rdy, wvalid} !== 2'b01) begin
                miscompares++;
                $display("FAIL hz_blocked_w%0d got rdy=%b wv=%b want 0 1", k, d_rd_rdy, wvalid);
            end
            tick();
        end
        wready = 1'b0; bvalid = 1'b1;
        #1;
        vectors++;
        if ({d_wr_done, d_rd_rdy} !== 2'b10) begin
            miscompares++;
            $display("FAIL hz_at_done got done=%b rdy=%b want 1 0", d_wr_done, d_rd_rdy);
        end
        tick();
        bvalid = 1'b0;
        #1;
        vectors++;
        if (d_rd_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL hz_release got %b want 1", d_rd_rdy);
        end
        tick();
        d_rd_req = 1'b0; arready = 1'b1;
        #1;
        vectors++;
        if ({arvalid, arid, araddr} !== {1'b1, 4'd1, 32'h108}) begin
            miscompares++;
            $display("FAIL hz_late_ar got v=%b id=%h a=%h want 1 1 00000108", arvalid, arid, araddr);
        end
        tick();
        arready = 1'b0; rvalid = 1'b1; rlast = 1'b1; rdata = 32'h66;
        tick();
        rvalid = 1'b0; rlast = 1'b0;
        $display("test_hazard: read 108 held behind write 100, read 200 passed");
    endtask

    task automatic test_reset_mid_burst();
        tick();
        i_rd_req = 1'b1; i_rd_type = 3'b100; i_rd_addr = 32'h1C00_0100;
        d_wr_req = 1'b1; d_wr_type = 3'b100; d_wr_addr = 32'h300; d_wr_wstrb = 4'hF;
        #1;
        vectors++;
        if ({i_rd_rdy, d_wr_rdy} !== 2'b11) begin
            miscompares++;
            $display("FAIL rb_concurrent got %b want 11", {i_rd_rdy, d_wr_rdy});
        end
        tick();
        i_rd_req = 1'b0; d_wr_req = 1'b0; arready = 1'b1;
        #1;
        vectors++;
        if ({arvalid, awvalid} !== 2'b11) begin
            miscompares++;
            $display("FAIL rb_both_addr got %b want 11", {arvalid, awvalid});
        end
        tick();
        arready = 1'b0; rvalid = 1'b1; rdata = 32'h1; rlast = 1'b0;
        #1;
        vectors++;
        if (i_ret_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL rb_beat1 got %b want 1", i_ret_valid);
        end
        tick();
        rdata = 32'h2; aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        #1;
        vectors++;
        if ({arvalid, rready, i_ret_valid, d_ret_valid, awvalid, wvalid, bready, d_wr_done} !== 8'h00) begin
            miscompares++;
            $display("FAIL rb_valids got %b want 00000000",
                     {arvalid, rready, i_ret_valid, d_ret_valid, awvalid, wvalid, bready, d_wr_done});
        end
        vectors++;
        if (d_wr_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL rb_wr_idle got %b want 1", d_wr_rdy);
        end
        rvalid = 1'b0;
        d_rd_req = 1'b1; d_rd_type = 3'b010; d_rd_addr = 32'h400;
        #1;
        vectors++;
        if (d_rd_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL rb_post_grant got %b want 1", d_rd_rdy);
        end
        tick();
        d_rd_req = 1'b0; arready = 1'b1;
        #1;
        vectors++;
        if ({arvalid, arid, araddr, arlen} !== {1'b1, 4'd1, 32'h400, 8'd0}) begin
            miscompares++;
            $display("FAIL rb_post_ar got v=%b id=%h a=%h len=%h want 1 1 00000400 00",
                     arvalid, arid, araddr, arlen);
        end
        tick();
        arready = 1'b0; rvalid = 1'b1; rlast = 1'b1; rdata = 32'h77;
        #1;
        vectors++;
        if ({d_ret_valid, d_ret_data} !== {1'b1, 32'h77}) begin
            miscompares++;
            $display("FAIL rb_post_beat got v=%b d=%h want 1 00000077", d_ret_valid, d_ret_data);
        end
        tick();
        rvalid = 1'b0; rlast = 1'b0;
        $display("test_reset_mid_burst: reset during beat 2, read 400 afterwards");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        aresetn = 1'b0;
        arready = 1'b0; rid = 4'd0; rdata = 32'd0; rresp = 2'd0; rlast = 1'b0; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bid = 4'd0; bresp = 2'd0; bvalid = 1'b0;
        i_rd_req = 1'b0; i_rd_type = 3'd0; i_rd_addr = 32'd0;
        d_rd_req = 1'b0; d_rd_type = 3'd0; d_rd_addr = 32'd0;
        d_wr_req = 1'b0; d_wr_type = 3'd0; d_wr_addr = 32'd0; d_wr_wstrb = 4'd0; d_wr_data = '0;
        test_reset();
        test_inst_line();
        test_priority();
        test_line_write();
        test_byte_write();
        test_hazard();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
